// File: rtl/dm_resp.sv
// dm_resp: single-port data memory with a two-state request/response handshake and a memory-mapped cycle counter.
module dm_resp #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] CNT_ADDR    = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic [31:0] Data_out,
    output logic        ready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, dout_q, dout_d;
    logic        ready_q, ready_d, err_q, err_d;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rword, wdata, ldata;
    logic [15:0] hsel;
    logic [7:0]  bsel;
    logic [3:0]  be;
    logic [AW-1:0] idx;
    logic        accept, we, bad, is_word, is_half, is_cnt, in_range;

    always_comb begin
        idx      = Addr_in[AW+1:2];
        is_word  = DMType == 3'd0;
        is_half  = DMType == 3'd1 || DMType == 3'd2;
        is_cnt   = Addr_in == CNT_ADDR;
        in_range = Addr_in[31:AW+2] == '0;
        bad      = (mem_r && mem_w) || DMType > 3'd4
                 || (is_word && Addr_in[1:0] != 2'd0) || (is_half && Addr_in[0])
                 || (!in_range && !is_cnt) || (is_cnt && !is_word);
        accept   = state_q == IDLE && (mem_r || mem_w);
        we       = accept && mem_w && !bad;
        be       = is_word ? 4'hF : is_half ? (Addr_in[1] ? 4'hC : 4'h3) : 4'b0001 << Addr_in[1:0];
        // Replicating the right-aligned data puts it on every lane; byte enables pick the live ones.
        wdata    = is_word ? Data_in : is_half ? {2{Data_in[15:0]}} : {4{Data_in[7:0]}};
        rword    = is_cnt ? cnt_q : mem[idx];
        hsel     = Addr_in[1] ? rword[31:16] : rword[15:0];
        bsel     = rword[{Addr_in[1:0], 3'b000} +: 8];
        ldata    = is_word ? rword
                 : is_half ? {{16{hsel[15] && DMType == 3'd1}}, hsel}
                 : {{24{bsel[7] && DMType == 3'd3}}, bsel};
        state_d  = accept ? RESP : IDLE;
        ready_d  = accept;
        err_d    = accept && bad;
        dout_d   = !accept ? dout_q : bad ? 32'd0 : mem_r ? ldata : dout_q;
        cnt_d    = (we && is_cnt) ? Data_in : cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            dout_q  <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && we && !is_cnt)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign Data_out = dout_q;
    assign ready    = ready_q;
    assign err      = err_q;
endmodule

// File: tb/tb_dm_resp.sv
// tb_dm_resp: randomized scoreboard bench for dm_resp against a byte-array memory and cycle-count model.
module tb_dm_resp;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CNT   = 32'h0000_FF00;

    logic        clk = 0, rst = 0, mem_r = 0, mem_w = 0;
    logic [31:0] Addr_in = 0, Data_in = 0, Data_out;
    logic [2:0]  DMType = 0;
    logic        ready, err;

    dm_resp #(.DEPTH_WORDS(DEPTH), .CNT_ADDR(CNT)) dut (
        .clk(clk), .rst(rst), .mem_r(mem_r), .mem_w(mem_w), .Addr_in(Addr_in),
        .Data_in(Data_in), .DMType(DMType), .Data_out(Data_out), .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {logic e; logic chk; logic [31:0] d;} exp_t;
    exp_t        q[$];
    logic [7:0]  mb [DEPTH*4];
    logic [31:0] cnt_m = 0, cnt_val = 0;
    logic        cnt_wr = 0;
    int          checks = 0, errors = 0, pulses = 0;

    // Reference counter: free-running cycle count, reloaded by an accepted word store to CNT.
    always @(posedge clk) cnt_m <= !rst ? 32'd0 : cnt_wr ? cnt_val : cnt_m + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t, input bit rst_in_resp);
        bit          word, half, byt, cnt, e;
        logic [31:0] v;
        int          n;
        word = t == 0; half = t == 1 || t == 2; byt = t == 3 || t == 4;
        cnt  = a == CNT;
        e = (r && w) || t > 4 || (word && a[1:0] != 0) || (half && a[0])
          || (!(a[31:2] < DEPTH) && !cnt) || (cnt && !word);
        v = 0;
        if (r && !e) begin
            if (cnt) v = cnt_m;
            else if (word) v = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
            else if (half) v = t == 1 ? {{16{mb[a+1][7]}}, mb[a+1], mb[a]} : {16'd0, mb[a+1], mb[a]};
            else v = t == 3 ? {{24{mb[a][7]}}, mb[a]} : {24'd0, mb[a]};
        end
        if (w && !e) begin
            if (cnt) begin cnt_wr = 1; cnt_val = d; end
            else if (word) {mb[a+3], mb[a+2], mb[a+1], mb[a]} = d;
            else if (half) {mb[a+1], mb[a]} = d[15:0];
            else mb[a] = d[7:0];
        end
        q.push_back('{e, r || e, v});
        mem_r = r; mem_w = w; Addr_in = a; Data_in = d; DMType = t;
        n = 0;
        do begin @(negedge clk); cnt_wr = 0; n++; end while (!ready && n < 6);
        chk("ready_timeout", {31'd0, ready}, 32'd1);
        mem_r = 0; mem_w = 0;
        if (rst_in_resp) begin
            rst = 0;
            @(negedge clk);
            chk("rst_resp_ready", {31'd0, ready}, 32'd0);
            chk("rst_resp_err", {31'd0, err}, 32'd0);
            chk("rst_resp_dout", Data_out, 32'd0);
            rst = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        int        p0, k;
        logic      r, w;
        logic [31:0] a;
        logic [2:0]  t;
        exp_t      x;
        logic      prev;
        prev = 0;
        fork
            forever begin
                @(negedge clk);
                if (ready === 1'b1) begin
                    pulses++;
                    chk("ready_consecutive", {31'd0, prev}, 32'd0);
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ready at %0t", $time);
                    end else begin
                        x = q.pop_front();
                        chk("resp_err", {31'd0, err}, {31'd0, x.e});
                        if (x.chk) chk("resp_data", Data_out, x.d);
                    end
                end
                prev = ready === 1'b1;
            end
        join_none
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_dout", Data_out, 32'd0);
        rst = 1;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) req(0, 1, i * 4, $urandom, 0, 0);
        req(0, 1, 32'h10, 32'hDEADBEEF, 0, 0);
        req(1, 0, 32'h10, 0, 0, 0);
        req(0, 1, 32'h10, 0, 0, 0);
        req(0, 1, 32'h13, 32'h80, 3, 0);
        req(1, 0, 32'h13, 0, 3, 0);
        req(1, 0, 32'h13, 0, 4, 0);
        req(1, 0, 32'h10, 0, 0, 0);
        req(1, 0, 32'h11, 0, 1, 0);
        req(1, 0, 32'h12, 0, 0, 0);
        req(0, 1, 32'h12, 32'h12345678, 0, 0);
        req(1, 0, DEPTH * 4, 0, 0, 0);
        req(0, 1, DEPTH * 4, 32'h55AA55AA, 0, 0);
        req(1, 0, 32'h10, 0, 0, 0);
        req(0, 1, CNT, 32'hFFFF_FFFE, 0, 0);
        req(1, 0, CNT, 0, 0, 0);
        repeat (2) @(negedge clk);
        req(1, 0, CNT, 0, 0, 0);
        req(1, 0, CNT, 0, 1, 0);
        req(1, 1, 32'h10, 32'h1234, 0, 0);
        req(1, 0, 32'h10, 0, 0, 0);
        req(0, 1, 32'h20, 32'hA5A5_5A5A, 0, 0);
        req(1, 0, 32'h20, 0, 0, 1);
        rst = 0; mem_w = 1; Addr_in = 32'h20; Data_in = 32'h0BAD_F00D; DMType = 0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, ready}, 32'd0);
        rst = 1; mem_w = 0;
        @(negedge clk);
        chk("rst_req_ready2", {31'd0, ready}, 32'd0);
        req(1, 0, 32'h20, 0, 0, 0);
        p0 = pulses;
        {mb[27], mb[26], mb[25], mb[24]} = 32'h1357_9BDF;
        q.push_back('{1'b0, 1'b0, 32'd0});
        q.push_back('{1'b0, 1'b0, 32'd0});
        mem_w = 1; Addr_in = 32'h18; Data_in = 32'h1357_9BDF; DMType = 0;
        repeat (4) @(negedge clk);
        mem_w = 0;
        chk("held_pulses", pulses - p0, 32'd2);
        @(negedge clk);
        req(1, 0, 32'h18, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 19);
            r = k < 9 || k >= 18;
            w = k >= 9;
            a = ($urandom_range(0, 15) == 0) ? CNT : 32'($urandom_range(0, DEPTH * 4 + 7));
            t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            if (a == CNT && $urandom_range(0, 3) != 0) t = 0;
            req(r, w, a, $urandom, t, 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
